// File: rtl/ipsxe_floating_point_lo_sub_pkg.sv
// Shared types and elaboration helpers for the chunk-serial low-part subtractor.
package ipsxe_floating_point_lo_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FINAL = 2'd2,
    HOLD  = 2'd3
  } state_t;

  function automatic int nchunk(input int lo_width, input int chunk_w);
    return lo_width / chunk_w;
  endfunction

  // A single-chunk configuration still needs a 1-bit index register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ipsxe_floating_point_chunk_sub_borrow_v1_0.sv
// Combinational CHUNK_W-bit subtract with borrow-in and borrow-out.
module ipsxe_floating_point_chunk_sub_borrow_v1_0 #(
  parameter int CHUNK_W = 10
) (
  input  logic [CHUNK_W-1:0] a,
  input  logic [CHUNK_W-1:0] b,
  input  logic               borrow_in,
  output logic [CHUNK_W-1:0] diff,
  output logic               borrow_out
);

  logic [CHUNK_W:0] diff_full;

  // The extra top bit goes to 1 exactly when a - b - borrow_in is negative.
  assign diff_full  = {1'b0, a} - {1'b0, b} - {{CHUNK_W{1'b0}}, borrow_in};
  assign diff       = diff_full[CHUNK_W-1:0];
  assign borrow_out = diff_full[CHUNK_W];

endmodule

// File: rtl/ipsxe_floating_point_lo_sub_carry_gen_v1_0.sv
// Chunk-serial a2_lo - a3y producing the low remainder and the signed carry
// field that the high-part adder sign-extends.
module ipsxe_floating_point_lo_sub_carry_gen_v1_0
  import ipsxe_floating_point_lo_sub_pkg::*;
#(
  parameter int LO_WIDTH = 40,
  parameter int CHUNK_W  = 10,
  parameter int CARRY_W  = 5
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [LO_WIDTH-1:0]           i_a2_lo,
  input  logic [LO_WIDTH+CARRY_W-2:0]   i_a3y,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [LO_WIDTH-1:0]           o_lo,
  output logic [CARRY_W-1:0]            o_carry_hi
);

  localparam int NCHUNK = nchunk(LO_WIDTH, CHUNK_W);
  localparam int IDX_W  = idx_width(NCHUNK);
  localparam int A3Y_W  = LO_WIDTH + CARRY_W - 1;

  if ((LO_WIDTH % CHUNK_W) != 0 || CARRY_W < 2) begin : g_param_check
    $error("LO_WIDTH must be a multiple of CHUNK_W and CARRY_W must be >= 2");
  end

  state_t               state_q, state_d;
  logic [LO_WIDTH-1:0]  a2_sh;
  logic [A3Y_W-1:0]     a3y_sh;
  logic [LO_WIDTH-1:0]  lo_q;
  logic [CARRY_W-1:0]   carry_q;
  logic [CARRY_W-1:0]   carry_final;
  logic                 borrow_q;
  logic [IDX_W-1:0]     idx_q;
  logic [CHUNK_W-1:0]   chunk_diff;
  logic                 chunk_borrow;
  logic                 accept;
  logic                 last_chunk;

  assign accept     = (state_q == IDLE) && i_valid;
  assign last_chunk = (idx_q == IDX_W'(NCHUNK - 1));

  ipsxe_floating_point_chunk_sub_borrow_v1_0 #(
    .CHUNK_W (CHUNK_W)
  ) u_chunk_sub (
    .a          (a2_sh[CHUNK_W-1:0]),
    .b          (a3y_sh[CHUNK_W-1:0]),
    .borrow_in  (borrow_q),
    .diff       (chunk_diff),
    .borrow_out (chunk_borrow)
  );

  // After NCHUNK right shifts the top CARRY_W-1 bits of a3y sit at the bottom.
  assign carry_final = CARRY_W'(0) - {1'b0, a3y_sh[CARRY_W-2:0]}
                     - {{(CARRY_W-1){1'b0}}, borrow_q};

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_valid)    state_d = CALC;
      CALC:    if (last_chunk) state_d = FINAL;
      FINAL:                   state_d = HOLD;
      HOLD:    if (i_ready)    state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      lo_q     <= '0;
      carry_q  <= '0;
      borrow_q <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (i_valid) begin
          borrow_q <= 1'b0;
          idx_q    <= '0;
        end
        CALC: begin
          lo_q[int'(idx_q)*CHUNK_W +: CHUNK_W] <= chunk_diff;
          borrow_q <= chunk_borrow;
          idx_q    <= idx_q + IDX_W'(1);
        end
        FINAL:   carry_q <= carry_final;
        default: ;
      endcase
    end
  end

  // NOTE: operand shift registers are pure datapath, loaded on accept, so they carry no reset.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      a2_sh  <= i_a2_lo;
      a3y_sh <= i_a3y;
    end else if (state_q == CALC) begin
      a2_sh  <= a2_sh >> CHUNK_W;
      a3y_sh <= a3y_sh >> CHUNK_W;
    end
  end

  assign o_ready    = (state_q == IDLE);
  assign o_valid    = (state_q == HOLD);
  assign o_lo       = lo_q;
  assign o_carry_hi = carry_q;

endmodule

// File: tb/tb_ipsxe_floating_point_lo_sub_carry_gen_v1_0.sv
// Scoreboard bench: stimulus pushes expected {carry, lo}; a monitor pops and compares.
module tb_ipsxe_floating_point_lo_sub_carry_gen_v1_0;

  localparam int LO = 40;
  localparam int CW = 5;
  localparam int AW = LO + CW - 1;
  localparam int LATENCY = 5;

  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [LO-1:0] i_a2_lo = '0;
  logic [AW-1:0] i_a3y = '0;
  logic          o_valid;
  logic          i_ready = 1'b1;
  logic [LO-1:0] o_lo;
  logic [CW-1:0] o_carry_hi;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [LO+CW-1:0] exp_q[$];
  int               acc_q[$];
  logic [LO+CW-1:0] cur_exp = '0;
  logic             prev_valid = 1'b0;
  logic             rand_ready = 1'b0;
  logic             manual_ready = 1'b1;

  ipsxe_floating_point_lo_sub_carry_gen_v1_0 dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_a2_lo    (i_a2_lo),
    .i_a3y      (i_a3y),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_lo       (o_lo),
    .o_carry_hi (o_carry_hi)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Golden model: exact difference, two's complement over LO+CW bits.
  function automatic logic [LO+CW-1:0] ref_diff(input logic [LO-1:0] a, input logic [AW-1:0] b);
    return {{CW{1'b0}}, a} - {1'b0, b};
  endfunction

  // Single driver of i_ready: random stalls or a value set by the main sequence.
  initial forever begin
    @(posedge clk);
    #2;
    i_ready = rand_ready ? ($urandom_range(0, 3) != 0) : manual_ready;
  end

  // Monitor: pops on the rising edge of o_valid, checks stability while held.
  always @(negedge clk) begin
    if (i_rst) begin
      prev_valid = 1'b0;
    end else begin
      if (o_valid) begin
        if (!prev_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_valid", 64'(o_valid), 64'd0);
          end else begin
            cur_exp = exp_q.pop_front();
            check("latency", 64'(cyc - acc_q.pop_front()), 64'(LATENCY));
          end
        end
        check("result", 64'({o_carry_hi, o_lo}), 64'(cur_exp));
        check("ready_low_in_hold", 64'(o_ready), 64'd0);
      end
      prev_valid = o_valid;
    end
  end

  // All stimulus tasks run in the posedge+1 phase.
  task automatic issue(input logic [LO-1:0] a2, input logic [AW-1:0] a3y, input logic [LO+CW-1:0] exp);
    int n = 0;
    while (o_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (o_ready !== 1'b1) check("ready_timeout", 64'(o_ready), 64'd1);
    i_valid = 1'b1;
    i_a2_lo = a2;
    i_a3y   = a3y;
    @(posedge clk); #1;
    exp_q.push_back(exp);
    acc_q.push_back(cyc);
    i_valid = 1'b0;
    // Scramble operands: only the accept edge may matter.
    i_a2_lo = LO'({$urandom(), $urandom()});
    i_a3y   = AW'({$urandom(), $urandom()});
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || o_valid) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 64'(o_ready), 64'd1);
    check({tag, "_valid"}, 64'(o_valid), 64'd0);
    check({tag, "_lo"}, 64'(o_lo), 64'd0);
    check({tag, "_carry"}, 64'(o_carry_hi), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LO-1:0] a2;
    logic [AW-1:0] a3y;
    int n;

    i_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    i_rst = 1'b0;
    check_reset_values("reset");

    issue(40'h00_0000_0005, 44'h003,           {5'h00, 40'h00_0000_0002});
    drain();
    issue(40'h0,            44'h1,             {5'h1F, 40'hFF_FFFF_FFFF});
    drain();
    issue(40'h0,            44'hFFF_FFFF_FFFF, {5'h10, 40'h00_0000_0001});
    drain();
    issue(40'hFF_FFFF_FFFF, 44'h0,             {5'h00, 40'hFF_FFFF_FFFF});
    drain();

    // Backpressure with an ignored i_valid pulse during HOLD.
    manual_ready = 1'b0;
    @(posedge clk); #1;
    issue(40'h12_3456_789A, 44'hABC_DEF0_1234, ref_diff(40'h12_3456_789A, 44'hABC_DEF0_1234));
    n = 0;
    while (!o_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_valid_seen", 64'(o_valid), 64'd1);
    for (int k = 0; k < 7; k++) begin
      if (k == 2) begin
        i_valid = 1'b1;
        i_a2_lo = 40'h1;
        i_a3y   = 44'h2;
      end
      if (k == 3) i_valid = 1'b0;
      @(posedge clk); #1;
    end
    check("bp_still_valid", 64'(o_valid), 64'd1);
    manual_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_valid_drop", 64'(o_valid), 64'd0);
    check("bp_ready_rise", 64'(o_ready), 64'd1);
    drain();

    // Reset during the second CALC cycle discards the operation.
    issue(40'h55_5555_5555, 44'h777_7777_7777, ref_diff(40'h55_5555_5555, 44'h777_7777_7777));
    @(posedge clk); #1;
    i_rst = 1'b1;
    @(posedge clk); #1;
    i_rst = 1'b0;
    exp_q.delete();
    acc_q.delete();
    check_reset_values("midreset");
    repeat (10) @(posedge clk);
    #1;
    issue(40'h00_0000_1000, 44'h000_0000_2000, {5'h1F, 40'hFF_FFFF_F000});
    drain();

    // Random operands with corner biasing and random i_ready stalls.
    rand_ready = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      a2  = LO'({$urandom(), $urandom()});
      a3y = AW'({$urandom(), $urandom()});
      case ($urandom_range(0, 7))
        0: a3y = '1;
        1: a2  = '0;
        2: a2  = '1;
        3: a3y = AW'(a2);
        default: ;
      endcase
      issue(a2, a3y, ref_diff(a2, a3y));
    end
    drain();
    rand_ready = 1'b0;
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
